rv32i_decode_exec: RTL and testbench
====================================

Name: rv32i_decode_exec

Overview:
- Combined RV32I decode, register-file and ALU slice for the 5-stage core.
- The decode and regfile-read paths serve the ID stage. The ALU path serves the EX stage. The regfile write port is driven by WB.
- The decode/ALU paths are purely combinational. Only the register array is clocked.

Parameters:
- NOP_INSTR, 32'h00000013, canonical NOP (addi x0,x0,0) used as the pipeline bubble.

Ports:
- clock  in  1  system clock; rising-edge active.
- reset  in  1  asynchronous, active-low; clears the register file.
- instr_raw  in  32  instruction in the ID stage.
- rd_addr  in  5  writeback destination; 0 means no write.
- w_val  in  32  writeback data.
- rs1_val  out  32  value of x[instr_raw[19:15]].
- rs2_val  out  32  value of x[instr_raw[24:20]].
- branch  out  1  conditional branch.
- mem_read  out  1  load.
- mem_write  out  1  store.
- alu_op  out  4  ALU operation code.
- alu_src  out  1  1 = ALU src2 is imm, 0 = rs2.
- reg_write  out  1  instruction writes rd.
- imm  out  32  sign-extended immediate.
- ex_alu_op  in  4  ALU operation for the EX stage.
- ex_src1  in  32  ALU operand 1.
- ex_src2  in  32  ALU operand 2.
- ex_result  out  32  ALU result.
- debug_ra, debug_sp, debug_t0, debug_t1, debug_t2, debug_a0, debug_a1  out  32 each  live contents of x1, x2, x5, x6, x7, x10, x11.

Behaviour:
- ALU op codes:
  - 0 NONE, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND, 11 EQ, 12 NE, 13 GE, 14 GEU.
  - 15 is reserved and behaves as NONE.
- ALU rules (combinational):
  - Results are mod 2^32.
  - Shift amount is ex_src2[4:0].
  - SLT/GE compare signed; SLTU/GEU compare unsigned.
  - Compare ops (SLT, SLTU, EQ, NE, GE, GEU) return 32'd1 or 32'd0.
  - NONE and reserved return 0.
- Decode (combinational). Fields: opcode = instr_raw[6:0], funct3, funct7[5] = instr_raw[30].
  - 0110011 R-type: reg_write=1, alu_src=0, imm=0.
    - funct3 000 → ADD, or SUB if bit30=1.
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
    - 101 → SRL, or SRA if bit30=1.
    - 110 OR, 111 AND.
  - 0010011 I-type ALU: reg_write=1, alu_src=1, imm = sext(instr[31:20]).
    - Op mapping as R-type, except funct3 000 is always ADD.
    - Shift ops are selected by bit30.
  - 0000011 load: mem_read=1, reg_write=1, alu_src=1, ADD, I-immediate. Only word loads are supported.
  - 0100011 store: mem_write=1, alu_src=1, ADD, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 branch: branch=1, alu_src=0, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
    - funct3 000 EQ, 001 NE, 100 SLT, 101 GE, 110 SLTU, 111 GEU.
    - funct3 010/011: all controls 0 (treated as NOP).
  - Any other opcode: all control outputs 0, alu_op=NONE, imm=0.
  - NOP_INSTR decodes to ADD with reg_write=1 to x0. This is harmless because x0 writes are discarded.
- Register file:
  - 32×32. x0 reads 0 always.
  - Two combinational read ports.
  - Write on rising clock when rd_addr≠0.
  - Write-through bypass: if rd_addr≠0 and rd_addr equals a read address in the same cycle, that port returns w_val.
  - Writes to x0 are discarded.
  - Debug outputs show the stored array contents (no bypass).
- Reset:
  - reset=0 asynchronously clears all 31 registers to 0, immediately; writes are blocked while asserted.
  - Outputs after reset: rs1_val/rs2_val/debug_* = 0.
  - Decode/ALU outputs depend only on their inputs.

Test Plan:
- Reset low mid-operation with x5=7 → debug_t0 reads 0 without a clock edge. After release, write rd=5 w_val=32'h12345678 and clock → debug_t0=32'h12345678.
- Write rd=0 w_val=32'hFFFFFFFF, then read x0 → rs1_val=0. Same-cycle rd=6 w_val=9 while instr rs1=6 → rs1_val=9 before the edge.
- Decode 32'hFFF00293 (addi t0,x0,-1) → reg_write=1, alu_src=1, alu_op=ADD, imm=32'hFFFFFFFF. Decode 32'h0062A423 (sw t1,8(t0)) → mem_write=1, imm=8, reg_write=0.
- Decode 32'hFE629EE3 (bne t0,t1,-4) → branch=1, alu_op=NE, alu_src=0, imm=32'hFFFFFFFC. Decode 32'h4062D3B3 (sra t2,t0,t1) → alu_op=SRA.
- ALU signedness: SUB 5-7 → 32'hFFFFFFFE. SRA 32'h80000000 by 4 → 32'hF8000000. SRL same → 32'h08000000. SLT(-1,1)=1 vs SLTU(-1,1)=0. GEU(0,0)=1. Op 15 → 0.
- Unknown opcode 32'h0000006F → all controls 0, alu_op=0, imm=0.

Source files
------------

// File: rtl/rv32i_decode_exec.sv
// RV32I ID/EX slice: instruction decode, 32x32 register file with
// write-through bypass, and the EX-stage ALU.
module rv32i_decode_exec #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_raw,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] w_val,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        reg_write,
  output logic [31:0] imm,
  input  logic [3:0]  ex_alu_op,
  input  logic [31:0] ex_src1,
  input  logic [31:0] ex_src2,
  output logic [31:0] ex_result,
  output logic [31:0] debug_ra,
  output logic [31:0] debug_sp,
  output logic [31:0] debug_t0,
  output logic [31:0] debug_t1,
  output logic [31:0] debug_t2,
  output logic [31:0] debug_a0,
  output logic [31:0] debug_a1
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_SLL = 4'd3,
    OP_SLT  = 4'd4,  OP_SLTU = 4'd5, OP_XOR = 4'd6,  OP_SRL = 4'd7,
    OP_SRA  = 4'd8,  OP_OR  = 4'd9,  OP_AND = 4'd10, OP_EQ  = 4'd11,
    OP_NE   = 4'd12, OP_GE  = 4'd13, OP_GEU = 4'd14
  } alu_op_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0] regs_reg [32];
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [2:0]  funct3;
  logic        bit30;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;

  assign rs1_addr = instr_raw[19:15];
  assign rs2_addr = instr_raw[24:20];
  assign funct3   = instr_raw[14:12];
  assign bit30    = instr_raw[30];
  assign imm_i    = {{20{instr_raw[31]}}, instr_raw[31:20]};
  assign imm_s    = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
  assign imm_b    = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7],
                     instr_raw[30:25], instr_raw[11:8], 1'b0};

  // Entry 0 is cleared on reset and never written, so it always holds zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_reg[i] <= '0;
    end else if (rd_addr != 5'd0) begin
      regs_reg[rd_addr] <= w_val;
    end
  end

  // Bypass is suppressed while reset is held since the write will not land.
  always_comb begin
    rs1_val = regs_reg[rs1_addr];
    rs2_val = regs_reg[rs2_addr];
    if (rs1_addr == 5'd0) rs1_val = '0;
    else if (reset && rd_addr == rs1_addr) rs1_val = w_val;
    if (rs2_addr == 5'd0) rs2_val = '0;
    else if (reset && rd_addr == rs2_addr) rs2_val = w_val;
  end

  assign debug_ra = regs_reg[1];
  assign debug_sp = regs_reg[2];
  assign debug_t0 = regs_reg[5];
  assign debug_t1 = regs_reg[6];
  assign debug_t2 = regs_reg[7];
  assign debug_a0 = regs_reg[10];
  assign debug_a1 = regs_reg[11];

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
    case (f3)
      3'b000:  arith_op = (allow_sub && alt) ? OP_SUB : OP_ADD;
      3'b001:  arith_op = OP_SLL;
      3'b010:  arith_op = OP_SLT;
      3'b011:  arith_op = OP_SLTU;
      3'b100:  arith_op = OP_XOR;
      3'b101:  arith_op = alt ? OP_SRA : OP_SRL;
      3'b110:  arith_op = OP_OR;
      default: arith_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    branch    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_op    = OP_NONE;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    imm       = '0;
    if (instr_raw == NOP_INSTR) begin
      // Bubble: ADD into x0, the write is dropped by the register file.
      alu_op    = OP_ADD;
      alu_src   = 1'b1;
      reg_write = 1'b1;
    end else begin
      case (instr_raw[6:0])
        OPC_R: begin
          reg_write = 1'b1;
          alu_op    = arith_op(funct3, bit30, 1'b1);
        end
        OPC_I: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = arith_op(funct3, bit30, 1'b0);
          imm       = imm_i;
        end
        OPC_LOAD: begin
          mem_read  = 1'b1;
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = OP_ADD;
          imm       = imm_i;
        end
        OPC_STORE: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = OP_ADD;
          imm       = imm_s;
        end
        OPC_BRANCH: begin
          if (funct3 != 3'b010 && funct3 != 3'b011) begin
            branch = 1'b1;
            imm    = imm_b;
            case (funct3)
              3'b000:  alu_op = OP_EQ;
              3'b001:  alu_op = OP_NE;
              3'b100:  alu_op = OP_SLT;
              3'b101:  alu_op = OP_GE;
              3'b110:  alu_op = OP_SLTU;
              default: alu_op = OP_GEU;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ex_alu_op)
      OP_ADD:  ex_result = ex_src1 + ex_src2;
      OP_SUB:  ex_result = ex_src1 - ex_src2;
      OP_SLL:  ex_result = ex_src1 << ex_src2[4:0];
      OP_SLT:  ex_result = {31'd0, $signed(ex_src1) < $signed(ex_src2)};
      OP_SLTU: ex_result = {31'd0, ex_src1 < ex_src2};
      OP_XOR:  ex_result = ex_src1 ^ ex_src2;
      OP_SRL:  ex_result = ex_src1 >> ex_src2[4:0];
      OP_SRA:  ex_result = $unsigned($signed(ex_src1) >>> ex_src2[4:0]);
      OP_OR:   ex_result = ex_src1 | ex_src2;
      OP_AND:  ex_result = ex_src1 & ex_src2;
      OP_EQ:   ex_result = {31'd0, ex_src1 == ex_src2};
      OP_NE:   ex_result = {31'd0, ex_src1 != ex_src2};
      OP_GE:   ex_result = {31'd0, $signed(ex_src1) >= $signed(ex_src2)};
      OP_GEU:  ex_result = {31'd0, ex_src1 >= ex_src2};
      default: ex_result = '0;
    endcase
  end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Directed plus randomized check of rv32i_decode_exec against a behavioural
// model of the decode tables, register file and ALU.
module tb_rv32i_decode_exec;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr_raw;
  logic [4:0]  rd_addr;
  logic [31:0] w_val;
  logic [31:0] rs1_val, rs2_val;
  logic        branch, mem_read, mem_write, alu_src, reg_write;
  logic [3:0]  alu_op;
  logic [31:0] imm;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_src1, ex_src2, ex_result;
  logic [31:0] debug_ra, debug_sp, debug_t0, debug_t1, debug_t2, debug_a0, debug_a1;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] model_regs [32];

  typedef struct packed {
    logic        br;
    logic        mr;
    logic        mw;
    logic [3:0]  op;
    logic        src;
    logic        rw;
    logic [31:0] imm;
  } dec_t;

  rv32i_decode_exec dut (
    .clock(clock), .reset(reset), .instr_raw(instr_raw), .rd_addr(rd_addr),
    .w_val(w_val), .rs1_val(rs1_val), .rs2_val(rs2_val), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
    .alu_src(alu_src), .reg_write(reg_write), .imm(imm),
    .ex_alu_op(ex_alu_op), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_result(ex_result), .debug_ra(debug_ra), .debug_sp(debug_sp),
    .debug_t0(debug_t0), .debug_t1(debug_t1), .debug_t2(debug_t2),
    .debug_a0(debug_a0), .debug_a1(debug_a1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    logic [3:0] arith [8];
    logic [3:0] cmp [8];
    logic [2:0] f3;
    d = '0;
    f3 = i[14:12];
    arith = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};
    cmp   = '{4'd11, 4'd12, 4'd0, 4'd0, 4'd4, 4'd13, 4'd5, 4'd14};
    case (i[6:0])
      7'h33: begin
        d.rw = 1'b1;
        d.op = arith[f3];
        if (i[30] && f3 == 3'd0) d.op = 4'd2;
        if (i[30] && f3 == 3'd5) d.op = 4'd8;
      end
      7'h13: begin
        d.rw = 1'b1; d.src = 1'b1;
        d.op = arith[f3];
        if (i[30] && f3 == 3'd5) d.op = 4'd8;
        d.imm = {{20{i[31]}}, i[31:20]};
      end
      7'h03: begin
        d.mr = 1'b1; d.rw = 1'b1; d.src = 1'b1; d.op = 4'd1;
        d.imm = {{20{i[31]}}, i[31:20]};
      end
      7'h23: begin
        d.mw = 1'b1; d.src = 1'b1; d.op = 4'd1;
        d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'h63: begin
        if (f3 != 3'd2 && f3 != 3'd3) begin
          d.br = 1'b1;
          d.op = cmp[f3];
          d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    longint sa, sb;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a << sh;
      4'd4:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return a ^ b;
      4'd7:  return a >> sh;
      4'd8:  return 32'((sa >>> sh) & 64'hFFFF_FFFF);
      4'd9:  return a | b;
      4'd10: return a & b;
      4'd11: return (a == b) ? 32'd1 : 32'd0;
      4'd12: return (a != b) ? 32'd1 : 32'd0;
      4'd13: return (sa >= sb) ? 32'd1 : 32'd0;
      4'd14: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (rd_addr == a) return w_val;
    return model_regs[a];
  endfunction

  task automatic check_decode(input string tag);
    dec_t d;
    d = ref_decode(instr_raw);
    check({tag, ".branch"},    {31'd0, branch},    {31'd0, d.br});
    check({tag, ".mem_read"},  {31'd0, mem_read},  {31'd0, d.mr});
    check({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, d.mw});
    check({tag, ".alu_op"},    {28'd0, alu_op},    {28'd0, d.op});
    check({tag, ".alu_src"},   {31'd0, alu_src},   {31'd0, d.src});
    check({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, d.rw});
    check({tag, ".imm"},       imm,                d.imm);
  endtask

  task automatic check_debug(input string tag);
    check({tag, ".ra"}, debug_ra, model_regs[1]);
    check({tag, ".sp"}, debug_sp, model_regs[2]);
    check({tag, ".t0"}, debug_t0, model_regs[5]);
    check({tag, ".t1"}, debug_t1, model_regs[6]);
    check({tag, ".t2"}, debug_t2, model_regs[7]);
    check({tag, ".a0"}, debug_a0, model_regs[10]);
    check({tag, ".a1"}, debug_a1, model_regs[11]);
  endtask

  task automatic write_clk(input logic [4:0] rd, input logic [31:0] v);
    @(negedge clock);
    rd_addr = rd; w_val = v;
    @(posedge clock);
    if (rd != 5'd0) model_regs[rd] = v;
    #1;
  endtask

  task automatic alu_case(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    ex_alu_op = op; ex_src1 = a; ex_src2 = b;
    #1;
    check(tag, ex_result, exp);
    check({tag, ".model"}, ref_alu(op, a, b), exp);
  endtask

  initial begin
    logic [6:0] opcs [6];
    dec_t d;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    reset = 1'b0; instr_raw = 32'h00000013; rd_addr = 5'd0; w_val = 32'd0;
    ex_alu_op = 4'd0; ex_src1 = 32'd0; ex_src2 = 32'd0;
    #7;
    check("reset.rs1", rs1_val, 32'd0);
    check("reset.rs2", rs2_val, 32'd0);
    check_debug("reset.dbg");
    @(negedge clock);
    reset = 1'b1;

    // Asynchronous reset clears stored state without a clock edge.
    write_clk(5'd5, 32'd7);
    check("wr.t0", debug_t0, 32'd7);
    @(negedge clock);
    rd_addr = 5'd0;
    #2 reset = 1'b0;
    #1 check("async_rst.t0", debug_t0, 32'd0);
    model_regs[5] = 32'd0;
    @(negedge clock);
    rd_addr = 5'd5; w_val = 32'hDEADBEEF;
    @(posedge clock); #1;
    check("rst_block.t0", debug_t0, 32'd0);
    @(negedge clock);
    rd_addr = 5'd0; reset = 1'b1;
    write_clk(5'd5, 32'h12345678);
    check("post_rst.t0", debug_t0, 32'h12345678);

    // x0 stays zero; same-cycle write is bypassed to the read port.
    write_clk(5'd0, 32'hFFFFFFFF);
    @(negedge clock);
    rd_addr = 5'd0; instr_raw = 32'h00000013; #1;
    check("x0.rs1", rs1_val, 32'd0);
    rd_addr = 5'd6; w_val = 32'd9; instr_raw = 32'h00030013; #1;
    check("bypass.rs1", rs1_val, 32'd9);
    @(posedge clock); model_regs[6] = 32'd9; #1;
    check("bypass.t1", debug_t1, 32'd9);
    @(negedge clock); rd_addr = 5'd0;

    instr_raw = 32'hFFF00293; #1;
    check("addi.reg_write", {31'd0, reg_write}, 32'd1);
    check("addi.alu_src", {31'd0, alu_src}, 32'd1);
    check("addi.alu_op", {28'd0, alu_op}, 32'd1);
    check("addi.imm", imm, 32'hFFFFFFFF);
    instr_raw = 32'h0062A423; #1;
    check("sw.mem_write", {31'd0, mem_write}, 32'd1);
    check("sw.imm", imm, 32'd8);
    check("sw.reg_write", {31'd0, reg_write}, 32'd0);
    instr_raw = 32'hFE629EE3; #1;
    check("bne.branch", {31'd0, branch}, 32'd1);
    check("bne.alu_op", {28'd0, alu_op}, 32'd12);
    check("bne.alu_src", {31'd0, alu_src}, 32'd0);
    check("bne.imm", imm, 32'hFFFFFFFC);
    instr_raw = 32'h4062D3B3; #1;
    check("sra.alu_op", {28'd0, alu_op}, 32'd8);
    instr_raw = 32'h0000006F; #1;
    check("jal.ctrl", {26'd0, branch, mem_read, mem_write, alu_src, reg_write, 1'b0}, 32'd0);
    check("jal.alu_op", {28'd0, alu_op}, 32'd0);
    check("jal.imm", imm, 32'd0);
    instr_raw = 32'h00000013; #1;
    check_decode("nop");

    alu_case("alu.sub", 4'd2, 32'd5, 32'd7, 32'hFFFFFFFE);
    alu_case("alu.sra", 4'd8, 32'h80000000, 32'd4, 32'hF8000000);
    alu_case("alu.srl", 4'd7, 32'h80000000, 32'd4, 32'h08000000);
    alu_case("alu.slt", 4'd4, 32'hFFFFFFFF, 32'd1, 32'd1);
    alu_case("alu.sltu", 4'd5, 32'hFFFFFFFF, 32'd1, 32'd0);
    alu_case("alu.geu", 4'd14, 32'd0, 32'd0, 32'd1);
    alu_case("alu.rsvd", 4'd15, 32'h1234, 32'h5678, 32'd0);

    // Randomized transactions against the behavioural model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      @(negedge clock);
      r = $urandom;
      instr_raw = {r[31:7], opcs[$urandom_range(0, 5)]};
      if ($urandom_range(0, 7) == 0) instr_raw = $urandom;
      rd_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rd_addr = instr_raw[19:15];
      w_val = $urandom;
      ex_alu_op = 4'($urandom_range(0, 15));
      ex_src1 = $urandom;
      ex_src2 = ($urandom_range(0, 5) == 0) ? ex_src1 : $urandom;
      #1;
      check_decode("rnd.dec");
      check("rnd.rs1", rs1_val, ref_read(instr_raw[19:15]));
      check("rnd.rs2", rs2_val, ref_read(instr_raw[24:20]));
      check("rnd.alu", ex_result, ref_alu(ex_alu_op, ex_src1, ex_src2));
      @(posedge clock);
      if (rd_addr != 5'd0) model_regs[rd_addr] = w_val;
      #1;
      check_debug("rnd.dbg");
    end
    d = ref_decode(32'h0);
    check("model.zero", {28'd0, d.op}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
